// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port 256x8 synchronous RAM between NUM_REQ requesters.
// Commands are registered onto the RAM port; a 2-stage owner pipeline routes each response back.
module ram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [NUM_REQ*8-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [NUM_REQ-1:0]   wr_ack,
  output logic                 ram_we,
  output logic                 ram_re,
  output logic [7:0]           ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_data_out,
  input  logic                 ram_valid_out,
  output logic                 busy
);

  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            ram_we_q, ram_we_d;
  logic            ram_re_q, ram_re_d;
  logic [7:0]      ram_addr_q, ram_addr_d;
  logic [7:0]      ram_wdata_q, ram_wdata_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s1_v_q, s1_v_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic            s2_rd_q, s2_rd_d;
  logic            s2_wr_q, s2_wr_d;

  logic [ID_W:0]      scan_sum;
  logic [ID_W-1:0]    scan_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] hs_oh;
  logic               hs;
  logic [ID_W-1:0]    hs_id;
  logic               hs_we;
  logic [7:0]         hs_addr;
  logic [7:0]         hs_wdata;

  // Search starts one past the last granted requester and wraps modulo NUM_REQ.
  always_comb begin
    req_ready   = '0;
    grant_found = 1'b0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found         = 1'b1;
        req_ready[scan_idx] = 1'b1;
      end
    end
    if (!en || !rst) begin
      req_ready = '0;
    end
  end

  always_comb begin
    hs_oh    = req_valid & req_ready;
    hs       = |hs_oh;
    hs_id    = '0;
    hs_we    = 1'b0;
    hs_addr  = '0;
    hs_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_oh[i]) begin
        hs_id    = ID_W'(i);
        hs_we    = req_we[i];
        hs_addr  = req_addr[i*8 +: 8];
        hs_wdata = req_wdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    last_grant_d = hs ? hs_id : last_grant_q;
    ram_we_d     = hs & hs_we;
    ram_re_d     = hs & ~hs_we;
    ram_addr_d   = hs ? hs_addr : ram_addr_q;
    ram_wdata_d  = hs ? hs_wdata : ram_wdata_q;
    s1_id_d      = hs ? hs_id : s1_id_q;
    s1_v_d       = hs;
    s2_id_d      = s1_id_q;
    s2_rd_d      = s1_v_q & ram_re_q;
    s2_wr_d      = s1_v_q & ram_we_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ID_W'(NUM_REQ-1);
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      s1_id_q      <= '0;
      s1_v_q       <= 1'b0;
      s2_id_q      <= '0;
      s2_rd_q      <= 1'b0;
      s2_wr_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      s1_id_q      <= s1_id_d;
      s1_v_q       <= s1_v_d;
      s2_id_q      <= s2_id_d;
      s2_rd_q      <= s2_rd_d;
      s2_wr_q      <= s2_wr_d;
    end
  end

  // A RAM valid with no read in stage 2 is ignored.
  always_comb begin
    rsp_valid = '0;
    wr_ack    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = ram_valid_out & s2_rd_q & (s2_id_q == ID_W'(i));
      wr_ack[i]    = s2_wr_q & (s2_id_q == ID_W'(i));
    end
  end

  assign rsp_data  = ram_data_out;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = s1_v_q | s2_rd_q | s2_wr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vectors plus a scoreboarded random burst,
// with a behavioural 256x8 RAM that clears on reset and returns read data one cycle after RE.
module tb_ram_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [3:0]  wr_ack;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_data_out;
  logic        ram_valid_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] model_mem [256];
  int         model_last;
  logic [3:0] pv;
  logic [3:0] pw;
  logic [7:0] pa [4];
  logic [7:0] pd [4];
  logic       sv [4];
  logic       swe [4];
  int         sid [4];
  logic [7:0] sdat [4];

  ram_port_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .wr_ack(wr_ack),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_data_out(ram_data_out), .ram_valid_out(ram_valid_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
      ram_data_out  <= 8'h00;
      ram_valid_out <= 1'b0;
    end else begin
      ram_valid_out <= ram_re;
      if (ram_re) ram_data_out <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] we,
                               input logic [31:0] addrs, input logic [31:0] wdatas);
    req_valid = valid;
    req_we    = we;
    req_addr  = addrs;
    req_wdata = wdatas;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    repeat (2) nextCycle();
    rst = 1'b1;
  endtask

  task automatic newCmd(input int i);
    pw[i] = 1'($urandom_range(0, 1));
    pa[i] = 8'($urandom_range(0, 15));
    pd[i] = 8'($urandom_range(0, 255));
    pv[i] = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic [31:0] a_pack;
    logic [31:0] d_pack;
    logic [3:0]  exp_ready;
    int          g;
    int          slot;

    rst = 1'b0;
    en  = 1'b1;
    applyStimulus(4'hF, 4'h0, 32'h0, 32'h0);
    repeat (2) nextCycle();
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_ram_we", 32'(ram_we), 32'h0);
    checkOutput("reset_ram_re", 32'(ram_re), 32'h0);
    checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("reset_ram_wdata", 32'(ram_wdata), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_wr_ack", 32'(wr_ack), 32'h0);
    rst = 1'b1;

    // Round-robin: all four hold reads at addr 4*i, grants 0,1,2,3,0.
    applyStimulus(4'hF, 4'h0, {8'd12, 8'd8, 8'd4, 8'd0}, 32'h0);
    for (int c = 0; c < 7; c++) begin
      if (c == 5) applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
      #1;
      checkOutput("rr_ready", 32'(req_ready), (c < 5) ? (32'd1 << (c % 4)) : 32'h0);
      checkOutput("rr_rsp_valid", 32'(rsp_valid), (c >= 2) ? (32'd1 << ((c - 2) % 4)) : 32'h0);
      if (c >= 1 && c <= 5) checkOutput("rr_ram_addr", 32'(ram_addr), 32'(4 * ((c - 1) % 4)));
      nextCycle();
    end
    repeat (2) nextCycle();

    // Write then read by requester 1.
    applyStimulus(4'b0010, 4'b0010, {8'h00, 8'h00, 8'h10, 8'h00}, {8'h00, 8'h00, 8'hA5, 8'h00});
    #1;
    checkOutput("wr_ready", 32'(req_ready), 32'h2);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, {8'h00, 8'h00, 8'h10, 8'h00}, 32'h0);
    #1;
    checkOutput("rd_ready", 32'(req_ready), 32'h2);
    checkOutput("wr_ram_we", 32'(ram_we), 32'h1);
    checkOutput("wr_ram_addr", 32'(ram_addr), 32'h10);
    checkOutput("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("wr_ack", 32'(wr_ack), 32'h2);
    checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rd_ram_re", 32'(ram_re), 32'h1);
    nextCycle();
    #1;
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("rd_rsp_data", 32'(rsp_data), 32'hA5);
    checkOutput("rd_wr_ack", 32'(wr_ack), 32'h0);
    nextCycle();
    #1;
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Pointer rotation: after grant to 2, requesters 0 and 3 compete.
    applyStimulus(4'b0100, 4'h0, {8'h00, 8'h10, 8'h00, 8'h00}, 32'h0);
    #1;
    checkOutput("rot_ready2", 32'(req_ready), 32'h4);
    nextCycle();
    applyStimulus(4'b1001, 4'h0, {8'h10, 8'h00, 8'h00, 8'h10}, 32'h0);
    #1;
    checkOutput("rot_ready3", 32'(req_ready), 32'h8);
    nextCycle();
    applyStimulus(4'b0001, 4'h0, {8'h00, 8'h00, 8'h00, 8'h10}, 32'h0);
    #1;
    checkOutput("rot_ready0", 32'(req_ready), 32'h1);
    checkOutput("rot_rsp2", 32'(rsp_valid), 32'h4);
    checkOutput("rot_data2", 32'(rsp_data), 32'hA5);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("rot_rsp3", 32'(rsp_valid), 32'h8);
    nextCycle();
    #1;
    checkOutput("rot_rsp0", 32'(rsp_valid), 32'h1);
    repeat (2) nextCycle();

    // Enable gating after a fresh reset.
    doReset();
    en = 1'b0;
    applyStimulus(4'hF, 4'h0, {8'd3, 8'd2, 8'd1, 8'd0}, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("en_ready", 32'(req_ready), 32'h0);
      checkOutput("en_ram_re", 32'(ram_re), 32'h0);
      checkOutput("en_ram_we", 32'(ram_we), 32'h0);
      nextCycle();
    end
    en = 1'b1;
    #1;
    checkOutput("en_resume", 32'(req_ready), 32'h1);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("en_resume_re", 32'(ram_re), 32'h1);
    repeat (3) nextCycle();

    // Reset in the cycle after a read handshake.
    applyStimulus(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h20}, {8'h00, 8'h00, 8'h00, 8'h5C});
    #1;
    checkOutput("mr_wr_ready", 32'(req_ready), 32'h1);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    repeat (3) nextCycle();
    applyStimulus(4'b0100, 4'h0, {8'h00, 8'h20, 8'h00, 8'h00}, 32'h0);
    #1;
    checkOutput("mr_rd_ready", 32'(req_ready), 32'h4);
    nextCycle();
    applyStimulus(4'hF, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mr_ram_re", 32'(ram_re), 32'h0);
    checkOutput("mr_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h0);
    checkOutput("mr_ready", 32'(req_ready), 32'h0);
    nextCycle();
    #1;
    checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("mr_wr_ack", 32'(wr_ack), 32'h0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("mr_post_rsp", 32'(rsp_valid), 32'h0);
    nextCycle();
    applyStimulus(4'b0100, 4'h0, {8'h00, 8'h20, 8'h00, 8'h00}, 32'h0);
    #1;
    checkOutput("mr_reread_ready", 32'(req_ready), 32'h4);
    nextCycle();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
    nextCycle();
    #1;
    checkOutput("mr_reread_rsp", 32'(rsp_valid), 32'h4);
    checkOutput("mr_reread_data", 32'(rsp_data), 32'h00);
    nextCycle();

    // Random back-to-back traffic against a scoreboard.
    doReset();
    model_last = NUM_REQ - 1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      newCmd(i);
      sv[i] = 1'b0; swe[i] = 1'b0; sid[i] = 0; sdat[i] = 8'h00;
    end
    if (pv == 4'h0) pv[0] = 1'b1;
    for (int c = 0; c < 202; c++) begin
      if (c < 200) begin
        for (int i = 0; i < 4; i++) begin
          a_pack[i*8 +: 8] = pa[i];
          d_pack[i*8 +: 8] = pd[i];
        end
        applyStimulus(pv, pw, a_pack, d_pack);
      end else begin
        applyStimulus(4'h0, 4'h0, 32'h0, 32'h0);
      end
      #1;
      g = -1;
      exp_ready = 4'h0;
      if (c < 200) begin
        for (int k = 1; k <= 4; k++) begin
          if (g < 0 && pv[(model_last + k) % 4]) g = (model_last + k) % 4;
        end
        exp_ready = 4'(1 << g);
      end
      checkOutput("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (c >= 1) checkOutput("rnd_busy", 32'(busy), 32'h1);
      slot = c % 4;
      checkOutput("rnd_rsp_valid", 32'(rsp_valid), (sv[slot] && !swe[slot]) ? (32'd1 << sid[slot]) : 32'h0);
      checkOutput("rnd_wr_ack", 32'(wr_ack), (sv[slot] && swe[slot]) ? (32'd1 << sid[slot]) : 32'h0);
      if (sv[slot] && !swe[slot]) checkOutput("rnd_rsp_data", 32'(rsp_data), 32'(sdat[slot]));
      sv[slot] = 1'b0;
      if (g >= 0) begin
        slot = (c + 2) % 4;
        sv[slot]  = 1'b1;
        swe[slot] = pw[g];
        sid[slot] = g;
        if (pw[g]) model_mem[pa[g]] = pd[g];
        else sdat[slot] = model_mem[pa[g]];
        model_last = g;
        newCmd(g);
        for (int i = 0; i < 4; i++) begin
          if (!pv[i]) newCmd(i);
        end
        if (pv == 4'h0) pv[(g + 1) % 4] = 1'b1;
      end
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares the single-port 256x8 synchronous RAM between `NUM_REQ` requesters. It accepts one read or write per cycle through per-requester valid/ready handshakes. Granted commands are registered onto the RAM port, and each read result is routed back to the requester that issued it. The block sits between the client masters and the RAM, and drives every RAM input.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the owner tag.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: arbitration enable; when low, no new grants are issued and in-flight operations complete.
- `req_valid`  in  NUM_REQ: per-requester command valid.
- `req_we`  in  NUM_REQ: per-requester command type; 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*8: packed addresses; requester i uses bits [8i+7:8i].
- `req_wdata`  in  NUM_REQ*8: packed write data, same packing as `req_addr`.
- `req_ready`  out  NUM_REQ: one-hot or zero grant; a command transfers when `req_valid[i]` & `req_ready[i]`.
- `rsp_valid`  out  NUM_REQ: one-cycle read-data-valid pulse to the owning requester.
- `rsp_data`  out  8: read data, shared by all requesters; qualified by `rsp_valid`.
- `wr_ack`  out  NUM_REQ: one-cycle write-completed pulse to the owning requester.
- `ram_we`, `ram_re`  out  1: RAM write/read enables; both are registered.
- `ram_addr`, `ram_wdata`  out  8: RAM address and write data; both are registered.
- `ram_data_out`  in  8: RAM read data.
- `ram_valid_out`  in  1: RAM read-valid, asserted one cycle after an `RE` edge.
- `busy`  out  1: high while any accepted command is still in the 2-stage pipeline.

## Operation
- **Arbitration.** Combinational round-robin over `req_valid`. Search starts at `last_grant+1` (mod NUM_REQ) and the first valid requester wins. `req_ready` is forced to 0 when `en`=0 or when `rst` is asserted.
- **req_ready depends on req_valid.** Requesters must not make `req_valid` depend on `req_ready`. Once raised, `req_valid` and its payload must be held until the handshake completes.
- **Pointer update.** `last_grant` is updated only on a completed handshake. Its reset value is `NUM_REQ-1`, so requester 0 has first priority.
- **Stage 1 (command register).** On a handshake, the block registers:
  - `ram_we` = `req_we[g]`
  - `ram_re` = `~req_we[g]`
  - `ram_addr` and `ram_wdata` from requester g
  - `s1_id` = g, `s1_v` = 1

  With no handshake, `ram_we`/`ram_re`/`s1_v` are set to 0 and `ram_addr`/`ram_wdata` hold their values.
- **Stage 2 (owner tracking).** `s2_id` <= `s1_id`, `s2_rd` <= `s1_v & ram_re`, `s2_wr` <= `s1_v & ram_we`.
- **Response routing.** `rsp_valid[i]` = `ram_valid_out & s2_rd & (s2_id==i)`. `rsp_data` = `ram_data_out`. `wr_ack[i]` = `s2_wr & (s2_id==i)`.
- **Ordering.** Commands reach the RAM strictly in grant order, so a read of an address written by an earlier-granted command returns the new data; no hazard logic is needed.
- **No backpressure.** Requesters must always accept `rsp_valid` and `wr_ack`.
- **busy** = `s1_v | s2_rd | s2_wr`.

## Timing
- **Reset values.** `ram_we`=0, `ram_re`=0, `ram_addr`=0, `ram_wdata`=0, `s1_v`=0, `s2_rd`=0, `s2_wr`=0, `s1_id`=0, `s2_id`=0, `last_grant`=NUM_REQ-1. Therefore `rsp_valid`=0, `wr_ack`=0, `busy`=0 and `req_ready`=0 during reset.
- **Read latency.** With the handshake in cycle A:
  - the RAM enables are high in A+1;
  - the RAM samples at the end of A+1;
  - `rsp_valid` and `rsp_data` are valid in A+2.
- **Write latency.** Handshake in A, RAM write at the end of A+1, `wr_ack` in A+2.
- **Throughput.** One command per cycle, sustained, for any mix of requesters.
- **Disabling.** `en` falling in cycle A blocks grants from cycle A onward. Operations accepted before A still produce their responses.
- **Reset mid-operation.** In-flight commands are discarded with no response, and the pointer returns to `NUM_REQ-1`. The RAM shares `rst` and clears its contents as well.
- **Spurious RAM valid.** `ram_valid_out` with `s2_rd`=0 is ignored.

## Test plan
- **Write then read.** Requester 1 writes 0xA5 to addr 0x10 (handshake in cycle 0), then reads 0x10 in cycle 1. Expect `wr_ack[1]` in cycle 2, then `rsp_valid[1]`=1 with `rsp_data`=0xA5 in cycle 3. All other `rsp_valid` bits stay 0.
- **Round-robin.** All 4 requesters hold reads (addr = 4·i) from cycle 0 after reset. Expect grants 0,1,2,3,0 in cycles 0..4 and responses routed to the same order in cycles 2..6.
- **Pointer rotation.** After a grant to requester 2, requesters 0 and 3 are valid together. Expect 3 granted first, then 0.
- **Enable gating.** `en`=0 with all requesters valid for 5 cycles. Expect `req_ready`=0 and `ram_we`=`ram_re`=0. Grants resume to requester 0 the cycle `en` returns to 1.
- **Reset mid-read.** Assert `rst` low in the cycle after a read handshake. Expect all outputs at their reset values, no `rsp_valid` pulse, and a subsequent read of any address returning 0x00.
- **Back-to-back traffic.** 200 random mixed read/write commands from all requesters, checked against a scoreboard model. Expect one command per cycle and every response matching the scoreboard, in order.
